// File: rtl/aclk_key_ctrl.sv
// Key-entry controller for the alarm clock: shift pulses, commit pulses, display select and entry timeout.
// Optional feature macro: ACLK_KEY_TIMEOUT_EN enables the inactivity timeout counter.
module aclk_key_ctrl #(
  parameter int unsigned TIMEOUT_S = 10,
  parameter logic [3:0]  NOKEY     = 4'hA
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       shift,
  output logic       show_new_time,
  output logic       show_a,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_ENTRY        = 3'd1,
    KEY_STORED       = 3'd2,
    SHOW_ALARM       = 3'd3,
    SET_ALARM_TIME   = 3'd4,
    SET_CURRENT_TIME = 3'd5,
    KEY_WAITED       = 3'd6
  } state_t;

  state_t state_r;
  state_t next_state_s;
  logic   timeout_s;
  logic   key_idle_s;

  assign key_idle_s = (key == NOKEY);

`ifdef ACLK_KEY_TIMEOUT_EN
  localparam logic [3:0] TIMEOUT_V = 4'(TIMEOUT_S);
  logic [3:0] count_r;

  // Inactivity counter: runs only while an entry is pending, saturates at the limit
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_r <= 4'd0;
    end else if ((state_r == KEY_WAITED) || (state_r == KEY_ENTRY)) begin
      if (one_second && (count_r != TIMEOUT_V)) begin
        count_r <= count_r + 4'd1;
      end else begin
        count_r <= count_r;
      end
    end else begin
      count_r <= 4'd0;
    end
  end

  assign timeout_s = (count_r == TIMEOUT_V);
`else
  logic unused_one_second_s;
  assign unused_one_second_s = one_second;
  assign timeout_s           = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= SHOW_TIME;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; buttons outrank timeout, which outranks a new key
  always_comb begin
    next_state_s = SHOW_TIME;
    case (state_r)
      SHOW_TIME: begin
        if (alarm_button) begin
          next_state_s = SHOW_ALARM;
        end else if (!key_idle_s) begin
          next_state_s = KEY_STORED;
        end else begin
          next_state_s = SHOW_TIME;
        end
      end
      KEY_STORED: next_state_s = KEY_WAITED;
      KEY_WAITED: begin
        if (key_idle_s) begin
          next_state_s = KEY_ENTRY;
        end else if (timeout_s) begin
          next_state_s = SHOW_TIME;
        end else begin
          next_state_s = KEY_WAITED;
        end
      end
      KEY_ENTRY: begin
        if (alarm_button) begin
          next_state_s = SET_ALARM_TIME;
        end else if (time_button) begin
          next_state_s = SET_CURRENT_TIME;
        end else if (timeout_s) begin
          next_state_s = SHOW_TIME;
        end else if (!key_idle_s) begin
          next_state_s = KEY_STORED;
        end else begin
          next_state_s = KEY_ENTRY;
        end
      end
      SHOW_ALARM: begin
        if (alarm_button) begin
          next_state_s = SHOW_ALARM;
        end else begin
          next_state_s = SHOW_TIME;
        end
      end
      SET_ALARM_TIME:   next_state_s = SHOW_TIME;
      SET_CURRENT_TIME: next_state_s = SHOW_TIME;
      default:          next_state_s = SHOW_TIME;
    endcase
  end

  // Moore outputs, registered from the state being entered so they track state_r exactly
  always_ff @(posedge clock) begin
    if (!reset) begin
      shift         <= 1'b0;
      show_new_time <= 1'b0;
      show_a        <= 1'b0;
      load_new_a    <= 1'b0;
      load_new_c    <= 1'b0;
    end else begin
      shift         <= (next_state_s == KEY_STORED);
      show_new_time <= (next_state_s == KEY_STORED) || (next_state_s == KEY_WAITED) ||
                       (next_state_s == KEY_ENTRY);
      show_a        <= (next_state_s == SHOW_ALARM);
      load_new_a    <= (next_state_s == SET_ALARM_TIME);
      load_new_c    <= (next_state_s == SET_CURRENT_TIME);
    end
  end

  assign fsm_state = state_r;

endmodule

// File: tb/tb_aclk_key_ctrl.sv
// Self-checking bench for aclk_key_ctrl: per-cycle reference model plus directed literal checks.
module tb_aclk_key_ctrl;

  localparam int unsigned TO_S  = 10;
  localparam logic [3:0]  NOKEY = 4'hA;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       one_second = 1'b0;
  logic [3:0] key = NOKEY;
  logic       alarm_button = 1'b0;
  logic       time_button = 1'b0;
  logic       shift, show_new_time, show_a, load_new_a, load_new_c;
  logic [2:0] fsm_state;

  aclk_key_ctrl #(.TIMEOUT_S(TO_S), .NOKEY(NOKEY)) dut (
    .clock(clock), .reset(reset), .one_second(one_second), .key(key),
    .alarm_button(alarm_button), .time_button(time_button),
    .shift(shift), .show_new_time(show_new_time), .show_a(show_a),
    .load_new_a(load_new_a), .load_new_c(load_new_c), .fsm_state(fsm_state)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int shift_cnt = 0;
  int la_cnt = 0;
  int lc_cnt = 0;
  logic [3:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a mode (what the display is doing) and seconds idle since the last stored key
  int  m_mode = 0;
  int  m_secs = 0;
  bit  m_to;
  bit  pending;
  logic [7:0] exp_v;

  always @(posedge clock) begin
    pending = (m_mode == 1) || (m_mode == 6);
`ifdef ACLK_KEY_TIMEOUT_EN
    m_to = (m_secs >= TO_S);
`else
    m_to = 1'b0;
`endif
    if (!reset) begin
      m_mode = 0;
      m_secs = 0;
    end else begin
      if (pending && one_second && (m_secs < TO_S)) m_secs = m_secs + 1;
      else if (!pending) m_secs = 0;
      case (m_mode)
        0: m_mode = alarm_button ? 3 : ((key != NOKEY) ? 2 : 0);
        2: m_mode = 6;
        6: m_mode = (key == NOKEY) ? 1 : (m_to ? 0 : 6);
        1: m_mode = alarm_button ? 4 : time_button ? 5 : m_to ? 0 : (key != NOKEY) ? 2 : 1;
        3: m_mode = alarm_button ? 3 : 0;
        default: m_mode = 0;
      endcase
    end
    #1;
    exp_v = {m_mode[2:0], m_mode == 2, (m_mode == 2) || (m_mode == 6) || (m_mode == 1),
             m_mode == 3, m_mode == 4, m_mode == 5};
    chk("cycle", {24'd0, fsm_state, shift, show_new_time, show_a, load_new_a, load_new_c},
        {24'd0, exp_v});
    if (shift === 1'b1) begin
      sb.push_back(key);
      shift_cnt++;
    end
    if (load_new_a === 1'b1) la_cnt++;
    if (load_new_c === 1'b1) lc_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  int s0, la0, lc0;

  initial begin
    tick(2);
    chk("reset_state", {fsm_state, shift, show_new_time, show_a, load_new_a, load_new_c}, 8'h00);
    reset = 1'b1;
    tick(1);

    // Four-digit time set
    for (int d = 1; d <= 4; d++) begin
      key = 4'(d);
      tick(3);
      key = NOKEY;
      tick(2);
    end
    time_button = 1'b1;
    tick(1);
    chk("set_time_load_c", {fsm_state, load_new_c}, {3'd5, 1'b1});
    time_button = 1'b0;
    tick(1);
    chk("set_time_back", fsm_state, 3'd0);
    chk("set_time_shifts", shift_cnt, 4);
    chk("set_time_loads", lc_cnt, 1);
    chk("sb_size", sb.size(), 4);
    for (int i = 0; i < 4; i++) chk("sb_digit", (i < sb.size()) ? sb[i] : 4'hF, i + 1);

    // Held key then reset in the middle of an entry
    s0 = shift_cnt;
    key = 4'd7;
    tick(50);
    chk("held_one_shift", shift_cnt - s0, 1);
    chk("held_state", fsm_state, 3'd6);
    key = NOKEY;
    tick(1);
    chk("held_release", fsm_state, 3'd1);
    reset = 1'b0;
    tick(1);
    chk("reset_mid_entry", {fsm_state, shift, show_new_time, show_a, load_new_a, load_new_c}, 8'h00);
    reset = 1'b1;
    tick(1);

    // Both buttons with a key in KEY_ENTRY: ALARM wins
    key = 4'd5;
    tick(3);
    key = NOKEY;
    tick(1);
    alarm_button = 1'b1;
    time_button = 1'b1;
    key = 4'd5;
    tick(1);
    chk("prio_flags", {load_new_a, load_new_c, shift, fsm_state}, {3'b100, 3'd4});
    alarm_button = 1'b0;
    time_button = 1'b0;
    key = NOKEY;
    tick(1);
    chk("prio_back", fsm_state, 3'd0);

    // Alarm display while ALARM is held
    alarm_button = 1'b1;
    tick(1);
    chk("alarm_show", {show_a, fsm_state}, {1'b1, 3'd3});
    tick(19);
    chk("alarm_still", show_a, 1'b1);
    alarm_button = 1'b0;
    tick(1);
    chk("alarm_release", {show_a, fsm_state}, {1'b0, 3'd0});

    // Timeout after one digit
    la0 = la_cnt;
    lc0 = lc_cnt;
    key = 4'd3;
    tick(3);
    key = NOKEY;
    tick(1);
`ifdef ACLK_KEY_TIMEOUT_EN
    repeat (10) begin
      one_second = 1'b1;
      tick(1);
      one_second = 1'b0;
      tick(1);
    end
    chk("timeout_state", fsm_state, 3'd0);
`else
    repeat (20) begin
      one_second = 1'b1;
      tick(1);
      one_second = 1'b0;
      tick(1);
    end
    chk("no_timeout_state", fsm_state, 3'd1);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
`endif
    chk("timeout_no_load", (la_cnt - la0) + (lc_cnt - lc0), 0);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aclk_key_ctrl.md
# aclk_key_ctrl

Key-entry controller for the alarm clock. Watches the keypad code and the ALARM/TIME buttons, generates the one-cycle `shift` pulse that clocks a new digit into the four-digit key buffer, and commits the buffered digits as the new alarm or current time. Selects what the display shows and abandons an unfinished entry after a timeout. Sits between the keypad scanner and the key buffer, alarm register and time counter.

## Interface
- `TIMEOUT_S`, default 10: whole seconds of keypad inactivity that abandon an entry. Legal range 1..15.
- `NOKEY`, default 4'hA: key code meaning "no key pressed".

Ports:
- `clock` input 1: single system clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-low reset, sampled on the rising edge of `clock`.
- `one_second` input 1: one-cycle pulse, once per second.
- `key` input 4: keypad code; 0..9 are digits, `NOKEY` means idle.
- `alarm_button` input 1: level, high while ALARM is held.
- `time_button` input 1: level, high while TIME is held.
- `shift` output 1: one-cycle pulse that loads `key` into the key buffer.
- `show_new_time` output 1: display shows the key buffer.
- `show_a` output 1: display shows the stored alarm.
- `load_new_a` output 1: one-cycle pulse that commits the buffer to the alarm register.
- `load_new_c` output 1: one-cycle pulse that commits the buffer to the time counter.
- `fsm_state` output 3: current state code, for debug.

## Operation
- State codes: SHOW_TIME=0, KEY_ENTRY=1, KEY_STORED=2, SHOW_ALARM=3, SET_ALARM_TIME=4, SET_CURRENT_TIME=5, KEY_WAITED=6. Codes 7 and above go to SHOW_TIME on the next edge.
- Outputs are Moore, decoded only from the state register:
  - `shift`=1 only in KEY_STORED.
  - `show_new_time`=1 in KEY_STORED, KEY_WAITED and KEY_ENTRY.
  - `show_a`=1 only in SHOW_ALARM.
  - `load_new_a`=1 only in SET_ALARM_TIME.
  - `load_new_c`=1 only in SET_CURRENT_TIME.
- Transitions, listed in priority order:
  - SHOW_TIME: `alarm_button` -> SHOW_ALARM; else `key`!=NOKEY -> KEY_STORED; else stay.
  - KEY_STORED: -> KEY_WAITED unconditionally. Exactly one `shift` per key press.
  - KEY_WAITED: `key`==NOKEY -> KEY_ENTRY; else timeout -> SHOW_TIME; else stay.
  - KEY_ENTRY: `alarm_button` -> SET_ALARM_TIME; else `time_button` -> SET_CURRENT_TIME; else timeout -> SHOW_TIME; else `key`!=NOKEY -> KEY_STORED; else stay.
  - SHOW_ALARM: `alarm_button` low -> SHOW_TIME; else stay.
  - SET_ALARM_TIME and SET_CURRENT_TIME: -> SHOW_TIME unconditionally.
- Simultaneous events:
  - ALARM beats TIME, and both beat key and timeout.
  - A key press in KEY_ENTRY on the same cycle as timeout is dropped; the state goes to SHOW_TIME.
- Timeout counter (4-bit):
  - Cleared while in SHOW_TIME, KEY_STORED, SHOW_ALARM, SET_ALARM_TIME or SET_CURRENT_TIME.
  - Increments on `one_second` while in KEY_WAITED or KEY_ENTRY.
  - Saturates at `TIMEOUT_S`.
  - timeout = (count == `TIMEOUT_S`). This is a combinational compare, so the transition happens on the edge after the count reaches `TIMEOUT_S`.

## Timing
- Reset: `reset` low at an edge gives, after that edge: state SHOW_TIME, counter 0, all outputs 0, `fsm_state`=0. This applies from any state, including mid-entry. Reset wins over every other input.
- Key press latency:
  - `key` becomes a digit before edge N while in SHOW_TIME or KEY_ENTRY.
  - `shift` is high for the cycle between edges N and N+1.
  - The buffer captures `key` at edge N+1. The scanner holds `key` stable for at least 2 cycles.
- Commit latency: a button sampled at edge N in KEY_ENTRY gives `load_new_a`/`load_new_c` high for one cycle after edge N. The state is SHOW_TIME after edge N+1.
- A held key never causes a second `shift`; a fresh `shift` requires `key`==NOKEY to be observed first.
- Timeout: the transition to SHOW_TIME occurs on the clock edge after the `TIMEOUT_S`-th `one_second` pulse counted since the last KEY_STORED.

## Configuration
- `ACLK_KEY_TIMEOUT_EN` defined: timeout counter and timeout transitions present as described above.
- `ACLK_KEY_TIMEOUT_EN` undefined: no counter and timeout is constant 0. KEY_WAITED and KEY_ENTRY wait indefinitely, and `one_second` is ignored. All other behaviour is identical.

## Test plan
- Reset mid-entry: in KEY_ENTRY, drive `reset`=0 for one edge -> `fsm_state`=0 and all outputs 0 at that edge.
- Four-digit time set:
  - Stimulus: keys 1,2,3,4, each held 3 cycles with NOKEY between, then `time_button` for one cycle.
  - Required response: exactly 4 `shift` pulses and then one `load_new_c` pulse. The scoreboard records `key` at each `shift` and expects 1,2,3,4.
- Held key: `key`=7 held for 50 cycles from SHOW_TIME -> exactly one `shift` pulse; state remains 6.
- Priority: in KEY_ENTRY, `alarm_button`=`time_button`=1 with `key`=5 -> `load_new_a`=1, `load_new_c`=0, `shift`=0.
- Alarm display: `alarm_button` held for 20 cycles in SHOW_TIME -> `show_a`=1 from the cycle after the first edge. Release -> `fsm_state`=0 one edge later.
- Timeout (macro defined, `TIMEOUT_S`=10): one digit entered, then 10 `one_second` pulses -> state 0 and no load pulse. With the macro undefined, 20 pulses -> state stays 1.
